// File: rtl/mindy_frame_sequencer.sv
// mindy_frame_sequencer: cuts a raw AXIS stream into frames of frame_beats beats and appends one meta-data beat per frame.
// Latency: frame data is a combinational pass-through; the MD beat is valid one cycle after the last frame beat.
// Backpressure: IN_TREADY follows FD_OUT_TREADY inside a frame; input is stalled while the MD beat waits for MD_OUT_TREADY.
//
// Ports:
//   clk, reset (async, active-high)
//   start (pulse), stop (level), frame_beats, frame_limit (0 = unlimited) -> busy, frames_done
//   AXIS_IN_*     : raw frame data in
//   AXIS_FD_OUT_* : gated frame data out
//   AXIS_MD_OUT_* : one meta-data beat per frame {marker, fb, ts0, fnum}
module mindy_frame_sequencer #(
  parameter int DATA_WBITS  = 512,
  parameter int BEAT_WBITS  = 16,
  parameter int FRAME_WBITS = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   stop,
  input  logic [BEAT_WBITS-1:0]  frame_beats,
  input  logic [FRAME_WBITS-1:0] frame_limit,
  output logic                   busy,
  output logic [FRAME_WBITS-1:0] frames_done,
  input  logic [DATA_WBITS-1:0]  AXIS_IN_TDATA,
  input  logic                   AXIS_IN_TVALID,
  output logic                   AXIS_IN_TREADY,
  output logic [DATA_WBITS-1:0]  AXIS_FD_OUT_TDATA,
  output logic                   AXIS_FD_OUT_TVALID,
  input  logic                   AXIS_FD_OUT_TREADY,
  output logic [DATA_WBITS-1:0]  AXIS_MD_OUT_TDATA,
  output logic                   AXIS_MD_OUT_TVALID,
  input  logic                   AXIS_MD_OUT_TREADY
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FRAME = 2'd1,
    S_MD    = 2'd2
  } state_t;

  localparam logic [BEAT_WBITS-1:0]  BEAT_ONE  = BEAT_WBITS'(1);
  localparam logic [FRAME_WBITS-1:0] FRAME_ONE = FRAME_WBITS'(1);
  localparam logic [15:0]            MD_MARKER = 16'hA5C3;

  state_t                 state_q, state_d;
  logic [31:0]            ts_q, ts_d;
  logic [BEAT_WBITS-1:0]  fb_q, fb_d;
  logic [FRAME_WBITS-1:0] fl_q, fl_d;
  logic [FRAME_WBITS-1:0] fnum_q, fnum_d;
  logic [BEAT_WBITS-1:0]  bcnt_q, bcnt_d;
  logic [31:0]            ts0_q, ts0_d;
  logic [FRAME_WBITS-1:0] frames_done_q, frames_done_d;
  logic                   busy_q, busy_d;
  logic                   md_vld_q, md_vld_d;
  logic [DATA_WBITS-1:0]  md_dat_q, md_dat_d;

  logic                   in_rdy;
  logic                   fd_vld;
  logic                   fd_hs;
  logic                   md_hs;
  logic [FRAME_WBITS-1:0] fnum_inc;
  logic [31:0]            fnum_ext;
  logic [15:0]            fb_ext;

  always_comb begin
    state_d       = state_q;
    ts_d          = ts_q + 32'd1;
    fb_d          = fb_q;
    fl_d          = fl_q;
    fnum_d        = fnum_q;
    bcnt_d        = bcnt_q;
    ts0_d         = ts0_q;
    frames_done_d = frames_done_q;
    busy_d        = busy_q;
    md_vld_d      = md_vld_q;
    md_dat_d      = md_dat_q;
    in_rdy        = 1'b0;
    fd_vld        = 1'b0;
    fd_hs         = 1'b0;
    md_hs         = 1'b0;
    fnum_inc      = fnum_q + FRAME_ONE;
    fnum_ext      = '0;
    fnum_ext[FRAME_WBITS-1:0] = fnum_q;
    fb_ext        = '0;
    fb_ext[BEAT_WBITS-1:0]    = fb_q;

    case (state_q)
      S_IDLE: begin
        if (start && (frame_beats != '0)) begin
          fb_d          = frame_beats;
          fl_d          = frame_limit;
          fnum_d        = '0;
          bcnt_d        = '0;
          frames_done_d = '0;
          busy_d        = 1'b1;
          state_d       = S_FRAME;
        end
      end

      S_FRAME: begin
        in_rdy = AXIS_FD_OUT_TREADY;
        fd_vld = AXIS_IN_TVALID;
        fd_hs  = AXIS_IN_TVALID & AXIS_FD_OUT_TREADY;
        if (fd_hs) begin
          if (bcnt_q == '0) begin
            ts0_d = ts_q;
          end
          if (bcnt_q == (fb_q - BEAT_ONE)) begin
            bcnt_d   = '0;
            md_vld_d = 1'b1;
            state_d  = S_MD;
            // ts0_d (not ts0_q) so a one-beat frame carries its own timestamp.
            md_dat_d        = '0;
            md_dat_d[31:0]  = fnum_ext;
            md_dat_d[63:32] = ts0_d;
            md_dat_d[79:64] = fb_ext;
            md_dat_d[95:80] = MD_MARKER;
          end else begin
            bcnt_d = bcnt_q + BEAT_ONE;
          end
        end else if (stop && (bcnt_q == '0)) begin
          // Only leave between frames; a stop seen mid-frame waits for the MD beat.
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end

      S_MD: begin
        md_hs = md_vld_q & AXIS_MD_OUT_TREADY;
        if (md_hs) begin
          md_vld_d      = 1'b0;
          fnum_d        = fnum_inc;
          frames_done_d = frames_done_q + FRAME_ONE;
          if (stop || ((fl_q != '0) && (fnum_inc == fl_q))) begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            state_d = S_FRAME;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      ts_q          <= '0;
      fb_q          <= '0;
      fl_q          <= '0;
      fnum_q        <= '0;
      bcnt_q        <= '0;
      ts0_q         <= '0;
      frames_done_q <= '0;
      busy_q        <= 1'b0;
      md_vld_q      <= 1'b0;
      md_dat_q      <= '0;
    end else begin
      state_q       <= state_d;
      ts_q          <= ts_d;
      fb_q          <= fb_d;
      fl_q          <= fl_d;
      fnum_q        <= fnum_d;
      bcnt_q        <= bcnt_d;
      ts0_q         <= ts0_d;
      frames_done_q <= frames_done_d;
      busy_q        <= busy_d;
      md_vld_q      <= md_vld_d;
      md_dat_q      <= md_dat_d;
    end
  end

  assign busy               = busy_q;
  assign frames_done        = frames_done_q;
  assign AXIS_IN_TREADY     = in_rdy;
  assign AXIS_FD_OUT_TDATA  = AXIS_IN_TDATA;
  assign AXIS_FD_OUT_TVALID = fd_vld;
  assign AXIS_MD_OUT_TDATA  = md_dat_q;
  assign AXIS_MD_OUT_TVALID = md_vld_q;

endmodule

// File: tb/tb_mindy_frame_sequencer.sv
// tb_mindy_frame_sequencer: directed bench for mindy_frame_sequencer.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the falling edge or mid-cycle.
// A negedge monitor records every FD/MD handshake with the cycle number at which it happens.
module tb_mindy_frame_sequencer;

  logic         clk;
  logic         reset;
  logic         start;
  logic         stop;
  logic [15:0]  frame_beats;
  logic [31:0]  frame_limit;
  logic         busy;
  logic [31:0]  frames_done;
  logic [511:0] in_dat;
  logic         in_vld;
  logic         in_rdy;
  logic [511:0] fd_dat;
  logic         fd_vld;
  logic         fd_rdy;
  logic [511:0] md_dat;
  logic         md_vld;
  logic         md_rdy;

  int           total;
  int           bad;
  logic [31:0]  cyc;
  logic [31:0]  base;
  logic [31:0]  fd_ts[$];
  logic [127:0] md_q[$];

  localparam logic [3:0] T5_VLD = 4'b0000;

  mindy_frame_sequencer dut (
    .clk                (clk),
    .reset              (reset),
    .start              (start),
    .stop               (stop),
    .frame_beats        (frame_beats),
    .frame_limit        (frame_limit),
    .busy               (busy),
    .frames_done        (frames_done),
    .AXIS_IN_TDATA      (in_dat),
    .AXIS_IN_TVALID     (in_vld),
    .AXIS_IN_TREADY     (in_rdy),
    .AXIS_FD_OUT_TDATA  (fd_dat),
    .AXIS_FD_OUT_TVALID (fd_vld),
    .AXIS_FD_OUT_TREADY (fd_rdy),
    .AXIS_MD_OUT_TDATA  (md_dat),
    .AXIS_MD_OUT_TVALID (md_vld),
    .AXIS_MD_OUT_TREADY (md_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference cycle count: zero out of reset, +1 per rising edge.
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= '0;
    else       cyc <= cyc + 32'd1;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    in_dat = {16{cyc ^ 32'hA5A5_0000}};
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("idle_timeout", {127'd0, busy}, 128'd0);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (fd_vld && fd_rdy) begin
        fd_ts.push_back(cyc);
        chk("fd_pass", fd_dat[127:0], in_dat[127:0]);
      end
      if (md_vld && md_rdy) md_q.push_back(md_dat[127:0]);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    total = 0; bad = 0;
    reset = 1'b1; start = 1'b0; stop = 1'b0;
    frame_beats = '0; frame_limit = '0;
    in_dat = '0; in_vld = 1'b0; fd_rdy = 1'b0; md_rdy = 1'b0;

    // ---- reset state ----
    repeat (2) @(negedge clk);
    chk("rst_busy",   {127'd0, busy},   128'd0);
    chk("rst_done",   {96'd0, frames_done}, 128'd0);
    chk("rst_mdvld",  {127'd0, md_vld}, 128'd0);
    chk("rst_inrdy",  {127'd0, in_rdy}, 128'd0);
    tick();
    reset = 1'b0;
    tick();

    // ---- 1: fb=4 fl=2, free-flowing ----
    fd_ts.delete(); md_q.delete();
    frame_beats = 16'd4; frame_limit = 32'd2; start = 1'b1;
    in_vld = 1'b1; fd_rdy = 1'b1; md_rdy = 1'b1;
    tick();
    start = 1'b0;
    chk("t1_busy", {127'd0, busy}, 128'd1);
    wait_idle(100);
    chk("t1_fd_n",    fd_ts.size(), 8);
    chk("t1_md_n",    md_q.size(), 2);
    chk("t1_md0_fn",  md_q[0][31:0], 0);
    chk("t1_md1_fn",  md_q[1][31:0], 1);
    chk("t1_md0_fb",  md_q[0][79:64], 4);
    chk("t1_md1_mk",  md_q[1][95:80], 16'hA5C3);
    chk("t1_md0_hi",  md_q[0][127:96], 0);
    chk("t1_md0_ts",  md_q[0][63:32], fd_ts[0]);
    chk("t1_ts_step", md_q[1][63:32] - md_q[0][63:32], 5);
    chk("t1_stall",   fd_ts[4] - fd_ts[3], 2);
    chk("t1_done",    frames_done, 2);

    // ---- 2: fb=3 fl=1, MD held off 5 cycles; start on the final MD handshake ----
    fd_ts.delete(); md_q.delete();
    tick();
    frame_beats = 16'd3; frame_limit = 32'd1; start = 1'b1; md_rdy = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (md_vld) break;
    end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("t2_mdvld",  {127'd0, md_vld}, 128'd1);
      chk("t2_inrdy",  {127'd0, in_rdy}, 128'd0);
      chk("t2_mddat",  md_dat[127:0], {32'd0, 16'hA5C3, 16'd3, fd_ts[0], 32'd0});
    end
    tick();
    md_rdy = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle(20);
    repeat (3) tick();
    chk("t2_nostart", {127'd0, busy}, 128'd0);
    chk("t2_md_n",    md_q.size(), 1);
    chk("t2_fd_n",    fd_ts.size(), 3);
    chk("t2_done",    frames_done, 1);

    // ---- 3: fb=4 unlimited, stop after beat 2 of frame 2 ----
    fd_ts.delete(); md_q.delete();
    frame_beats = 16'd4; frame_limit = 32'd0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 100 && fd_ts.size() < 10; i++) @(posedge clk);
    #1 stop = 1'b1;
    wait_idle(50);
    stop = 1'b0;
    chk("t3_fd_n",   fd_ts.size(), 12);
    chk("t3_md_n",   md_q.size(), 3);
    chk("t3_md2_fn", md_q[2][31:0], 2);
    chk("t3_done",   frames_done, 3);

    // ---- 4: start with frame_beats=0, then start while busy ----
    fd_ts.delete(); md_q.delete();
    tick();
    frame_beats = 16'd0; frame_limit = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    chk("t4_zero_busy", {127'd0, busy}, 128'd0);
    chk("t4_zero_fd",   fd_ts.size(), 0);
    chk("t4_zero_done", frames_done, 3);
    frame_beats = 16'd2; frame_limit = 32'd2; start = 1'b1;
    tick();
    start = 1'b0; frame_beats = 16'd7; frame_limit = 32'd5;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle(50);
    chk("t4_fd_n",  fd_ts.size(), 4);
    chk("t4_md_n",  md_q.size(), 2);
    chk("t4_md_fb", md_q[1][79:64], 2);
    chk("t4_done",  frames_done, 2);

    // ---- 5: fb=2 with valid gaps and ready toggling ----
    fd_ts.delete(); md_q.delete();
    tick();
    frame_beats = 16'd2; frame_limit = 32'd1; start = 1'b1; in_vld = 1'b0; fd_rdy = 1'b1;
    tick();
    start = 1'b0;
    base = cyc;
    // c0: v0 r1 | c1: v1 r0 | c2: v1 r1 (beat 0) | c3: v0 r1 | c4: v1 r0 | c5: v1 r1 (beat 1)
    for (int c = 0; c < 6; c++) begin
      logic [5:0] vv;
      logic [5:0] rv;
      vv = 6'b110110;
      rv = 6'b101101;
      if (c > 0) tick();
      in_vld = vv[c];
      fd_rdy = rv[c];
      #2;
      if (c == 1) chk("t5_inrdy_c1", {127'd0, in_rdy}, 128'd0);
      if (c == 3) chk("t5_fdvld_c3", {127'd0, fd_vld}, 128'd0);
      if (c == 5) chk("t5_mdvld_c5", {127'd0, md_vld}, {124'd0, T5_VLD});
    end
    tick();
    in_vld = 1'b0;
    chk("t5_mdvld_c6", {127'd0, md_vld}, 128'd1);
    wait_idle(20);
    chk("t5_fd_n",  fd_ts.size(), 2);
    chk("t5_md_n",  md_q.size(), 1);
    chk("t5_ts0",   md_q[0][63:32], base + 32'd2);
    chk("t5_fb",    md_q[0][79:64], 2);

    // ---- 6: asynchronous reset mid-frame ----
    fd_ts.delete(); md_q.delete();
    tick();
    frame_beats = 16'd4; frame_limit = 32'd0; start = 1'b1;
    in_vld = 1'b1; fd_rdy = 1'b1; md_rdy = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 50 && fd_ts.size() < 5; i++) @(posedge clk);
    #3;
    chk("t6_pre_done",  frames_done, 1);
    chk("t6_pre_inrdy", {127'd0, in_rdy}, 128'd1);
    reset = 1'b1;
    #1;
    chk("t6_busy",  {127'd0, busy},   128'd0);
    chk("t6_done",  frames_done, 0);
    chk("t6_inrdy", {127'd0, in_rdy}, 128'd0);
    chk("t6_fdvld", {127'd0, fd_vld}, 128'd0);
    chk("t6_mdvld", {127'd0, md_vld}, 128'd0);
    fd_ts.delete(); md_q.delete();
    tick();
    tick();
    reset = 1'b0;
    repeat (8) tick();
    chk("t6_post_fd",   fd_ts.size(), 0);
    chk("t6_post_md",   md_q.size(), 0);
    chk("t6_post_busy", {127'd0, busy}, 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mindy_frame_sequencer.md
Name: mindy_frame_sequencer

Overview:
- Sits upstream of the mindy interface block and drives both of its input streams.
- Gates a raw frame-data stream into fixed-length frames of frame_beats beats and passes them through.
- After each frame, emits exactly one meta-data beat describing that frame.
- Runs for frame_limit frames, or until stop is asserted, then returns to idle.

Parameters:
- DATA_WBITS, 512: TDATA width of all streams; must be >= 128.
- BEAT_WBITS, 16: width of the beats-per-frame count.
- FRAME_WBITS, 32: width of the frame number, frame limit and frames_done; must be <= 32.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a run when idle.
- stop  in  1  level; end the run at the next frame boundary.
- frame_beats  in  BEAT_WBITS  beats per frame; sampled at start.
- frame_limit  in  FRAME_WBITS  frames per run, 0 = unlimited; sampled at start.
- busy  out  1  high while a run is active.
- frames_done  out  FRAME_WBITS  frames completed in the current/last run.
- AXIS_IN_TDATA  in  DATA_WBITS  raw frame data.
- AXIS_IN_TVALID  in  1  raw frame data valid.
- AXIS_IN_TREADY  out  1  raw frame data ready.
- AXIS_FD_OUT_TDATA  out  DATA_WBITS  frame data to the mindy interface.
- AXIS_FD_OUT_TVALID  out  1  frame data valid.
- AXIS_FD_OUT_TREADY  in  1  frame data ready.
- AXIS_MD_OUT_TDATA  out  DATA_WBITS  meta-data to the mindy interface.
- AXIS_MD_OUT_TVALID  out  1  meta-data valid.
- AXIS_MD_OUT_TREADY  in  1  meta-data ready.

Behaviour:
- Reset:
  - Single clock domain clk; reset is asynchronous and active-high.
  - On reset: state=IDLE; busy, frames_done, AXIS_MD_OUT_TVALID, all counters and MD register = 0.
  - Reset mid-frame or mid-MD abandons the run; no MD beat is emitted afterwards.
- Timestamp: free-running 32-bit cycle counter, cleared by reset, wraps 0xFFFFFFFF->0.
- Latched run values: fb (frame_beats), fl (frame_limit).
- Run counters: fnum (frame number), bcnt (beat count), ts0 (first-beat timestamp).
- State IDLE:
  - AXIS_IN_TREADY=0, AXIS_FD_OUT_TVALID=0.
  - start=1 and frame_beats!=0: latch fb, fl; clear fnum, bcnt, frames_done; busy<=1; go FRAME.
  - start with frame_beats==0 is ignored.
  - start while busy is ignored.
- State FRAME:
  - Combinational pass-through: FD_OUT_TDATA=IN_TDATA, FD_OUT_TVALID=IN_TVALID, IN_TREADY=FD_OUT_TREADY.
  - Handshake means IN_TVALID & FD_OUT_TREADY.
  - Handshake with bcnt==0: ts0<=timestamp.
  - Each handshake: bcnt<=bcnt+1.
  - Handshake with bcnt==fb-1: bcnt<=0; load MD register; MD_OUT_TVALID<=1 on the next edge (1-cycle latency); go MD.
  - stop=1 while bcnt==0 and no handshake this cycle: busy<=0; go IDLE.
  - stop during a partial frame is deferred to the frame end.
- MD register layout:
  - [31:0] fnum, zero-extended.
  - [63:32] ts0.
  - [79:64] fb, zero-extended to 16 bits.
  - [95:80] 16'hA5C3 marker.
  - All other bits 0.
- State MD:
  - IN_TREADY=0, FD_OUT_TVALID=0.
  - MD_OUT_TVALID held and TDATA stable until MD_OUT_TREADY.
  - On handshake: MD_OUT_TVALID<=0; fnum<=fnum+1; frames_done<=frames_done+1.
  - Next state IDLE (busy<=0) if stop=1, or fl!=0 and fnum+1==fl; otherwise FRAME.
- Throughput: at least one input-stall cycle per frame (the MD state); frames never overlap MD beats.
- Width/wrap:
  - fnum and frames_done wrap modulo 2^FRAME_WBITS in unlimited mode.
  - bcnt is BEAT_WBITS wide; fb=2^BEAT_WBITS-1 is legal.
- Simultaneous events:
  - Last-beat handshake with stop=1: the MD beat is still emitted, then IDLE.
  - start in the same cycle as the final MD handshake: ignored, since busy is still 1.

Test Plan:
- fb=4, fl=2, input always valid, both TREADYs high -> 8 FD beats and 2 MD beats; MD0 [31:0]=0, MD1 [31:0]=1; [79:64]=4; [95:80]=A5C3; IN_TREADY low exactly 1 cycle between frames; busy falls after 2nd MD; frames_done=2.
- fb=3, fl=1, MD_OUT_TREADY held low 5 cycles after MD_OUT_TVALID rises -> MD_OUT_TDATA stable, IN_TREADY=0 for all 5 cycles, then IDLE.
- fb=4, fl=0, stop asserted after 2nd beat of frame 3 -> frame 3 completes 4 beats, MD [31:0]=2 emitted, then IDLE; frames_done=3.
- start with frame_beats=0 -> busy stays 0, no traffic; start pulsed while busy -> no effect on counters.
- fb=2, FD_OUT_TREADY toggling 1,0,1 with IN_TVALID gaps -> ts0 equals the timestamp of the first accepted beat; bcnt counts only handshakes.
- reset asserted mid-frame (bcnt=1) -> all outputs 0 immediately (asynchronous); no MD beat emitted after release.
